// File: rtl/episode_controller.sv
// Episode sequencer for the 5x5 grid-world Q-learning datapath: walks the grid through the
// external transition block and hands each accepted (s, a, s') to the Q-update engine.
module episode_controller #(
    parameter int STATES_WIDTH   = 5,
    parameter int ACTIONS_WIDTH  = 2,
    parameter int START_STATE    = 0,
    parameter int GOAL_STATE     = 24,
    parameter int MAX_STEPS      = 64,
    parameter int STEP_CNT_WIDTH = 8,
    parameter int MAX_RETRIES    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_run,
    input  logic [ACTIONS_WIDTH-1:0]  i_random_action,
    output logic                      o_rand_req,
    output logic [STATES_WIDTH-1:0]   o_st,
    output logic [ACTIONS_WIDTH-1:0]  o_at,
    input  logic [STATES_WIDTH-1:0]   i_next_st,
    input  logic                      i_re_random,
    output logic                      o_step_valid,
    input  logic                      i_step_ready,
    output logic [STATES_WIDTH-1:0]   o_step_st,
    output logic [ACTIONS_WIDTH-1:0]  o_step_at,
    output logic [STATES_WIDTH-1:0]   o_step_next_st,
    output logic                      o_step_goal,
    output logic                      o_step_wall,
    output logic [STEP_CNT_WIDTH-1:0] o_step_cnt,
    output logic [15:0]               o_episode_cnt,
    output logic                      o_episode_done,
    output logic                      o_busy
);

    // state  | meaning
    // IDLE   | waiting for i_run
    // INIT   | load start state, clear step and retry counts
    // SELECT | request a random action and latch it into o_at
    // EVAL   | transition block result valid: accept, retry, or force a self-loop
    // ISSUE  | transition offered to the Q-update engine, held until ready
    // DONE   | episode finished: pulse done, bump episode count
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SELECT = 3'd2,
        EVAL   = 3'd3,
        ISSUE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int RETRY_WIDTH = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
    localparam logic [RETRY_WIDTH-1:0]    RETRY_LAST = RETRY_WIDTH'(MAX_RETRIES - 1);
    localparam logic [STATES_WIDTH-1:0]   START_ST   = STATES_WIDTH'(START_STATE);
    localparam logic [STATES_WIDTH-1:0]   GOAL_ST    = STATES_WIDTH'(GOAL_STATE);
    localparam logic [STEP_CNT_WIDTH-1:0] STEP_LAST  = STEP_CNT_WIDTH'(MAX_STEPS - 1);

    state_t                 state;
    logic [RETRY_WIDTH-1:0] retry;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            retry          <= '0;
            o_st           <= START_ST;
            o_at           <= '0;
            o_rand_req     <= 1'b0;
            o_step_valid   <= 1'b0;
            o_step_st      <= '0;
            o_step_at      <= '0;
            o_step_next_st <= '0;
            o_step_goal    <= 1'b0;
            o_step_wall    <= 1'b0;
            o_step_cnt     <= '0;
            o_episode_cnt  <= '0;
            o_episode_done <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            o_rand_req     <= 1'b0;
            o_episode_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_run) begin
                        state  <= INIT;
                        o_busy <= 1'b1;
                    end
                end
                INIT: begin
                    o_st       <= START_ST;
                    o_step_cnt <= '0;
                    retry      <= '0;
                    o_rand_req <= 1'b1;
                    state      <= SELECT;
                end
                SELECT: begin
                    o_at  <= i_random_action;
                    state <= EVAL;
                end
                EVAL: begin
                    if (!i_re_random) begin
                        o_step_st      <= o_st;
                        o_step_at      <= o_at;
                        o_step_next_st <= i_next_st;
                        o_step_goal    <= (i_next_st == GOAL_ST);
                        o_step_wall    <= 1'b0;
                        retry          <= '0;
                        o_step_valid   <= 1'b1;
                        state          <= ISSUE;
                    end else if (retry != RETRY_LAST) begin
                        retry      <= retry + 1'b1;
                        o_rand_req <= 1'b1;
                        state      <= SELECT;
                    end else begin
                        // Too many wall hits in a row: stay put and report it as a step.
                        o_step_st      <= o_st;
                        o_step_at      <= o_at;
                        o_step_next_st <= o_st;
                        o_step_goal    <= (o_st == GOAL_ST);
                        o_step_wall    <= 1'b1;
                        retry          <= '0;
                        o_step_valid   <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_step_ready) begin
                        o_step_valid <= 1'b0;
                        o_st         <= o_step_next_st;
                        o_step_cnt   <= o_step_cnt + 1'b1;
                        if (o_step_goal || (o_step_cnt == STEP_LAST)) begin
                            o_episode_done <= 1'b1;
                            state          <= DONE;
                        end else begin
                            o_rand_req <= 1'b1;
                            state      <= SELECT;
                        end
                    end
                end
                DONE: begin
                    o_episode_cnt <= o_episode_cnt + 1'b1;
                    if (i_run) begin
                        state <= INIT;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/episode_controller.md
# episode_controller

Sequencing controller for the grid-world state-transition block in the Q-learning datapath. It runs episodes on the 5x5 grid (states 0..24, actions 00 Right, 01 Up, 10 Left, 11 Down):
- drives the current state and action into the combinational transition block;
- requests a fresh random action whenever that block flags a wall hit;
- hands each accepted transition to the Q-update engine over a valid/ready handshake;
- ends each episode at the goal state or at a step limit.

## Interface

- STATES_WIDTH, 5, state index width
- ACTIONS_WIDTH, 2, action width
- START_STATE, 0, initial state of every episode
- GOAL_STATE, 24, terminal state
- MAX_STEPS, 64, step limit per episode; must satisfy 1 ≤ MAX_STEPS ≤ 2^STEP_CNT_WIDTH−1
- STEP_CNT_WIDTH, 8, step counter width
- MAX_RETRIES, 4, consecutive wall hits before a forced self-loop step; must be ≥ 1

Ports:

- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_run  in  1  level; enables episode execution; sampled only in IDLE and DONE
- i_random_action  in  ACTIONS_WIDTH  action from the random source; valid in SELECT
- o_rand_req  out  1  one-cycle pulse in SELECT; advances the random source
- o_st  out  STATES_WIDTH  current state, connects to the transition block i_st
- o_at  out  ACTIONS_WIDTH  current action, connects to the transition block i_at
- i_next_st  in  STATES_WIDTH  transition block result
- i_re_random  in  1  transition block wall flag
- o_step_valid  out  1  transition available for Q update
- i_step_ready  in  1  Q-update engine accepts the transition
- o_step_st, o_step_at, o_step_next_st  out  5/2/5  registered transition (s, a, s')
- o_step_goal  out  1  s' == GOAL_STATE
- o_step_wall  out  1  forced self-loop after MAX_RETRIES wall hits
- o_step_cnt  out  STEP_CNT_WIDTH  steps completed in the current episode
- o_episode_cnt  out  16  completed episodes; wraps at 2^16
- o_episode_done  out  1  one-cycle pulse per completed episode
- o_busy  out  1  high in every state except IDLE

## Operation

- FSM states: IDLE, INIT, SELECT, EVAL, ISSUE, DONE.
- IDLE: if i_run=1, go to INIT.
- INIT: o_st←START_STATE, o_step_cnt←0, retry←0; go to SELECT.
- SELECT: o_rand_req=1; o_at←i_random_action; go to EVAL.
- EVAL: the transition block sees the registered o_st/o_at. Three cases:
  - i_re_random=0: capture o_step_st=o_st, o_step_at=o_at, o_step_next_st=i_next_st, o_step_goal=(i_next_st==GOAL_STATE), o_step_wall=0, retry←0; go to ISSUE.
  - i_re_random=1 and retry<MAX_RETRIES−1: retry←retry+1; go to SELECT.
  - i_re_random=1 and retry==MAX_RETRIES−1: capture o_step_next_st=o_st, o_step_wall=1, o_step_goal=(o_st==GOAL_STATE), retry←0; go to ISSUE.
- ISSUE: o_step_valid=1. All o_step_* outputs stay stable until i_step_ready=1. On the handshake cycle:
  - o_st←o_step_next_st; o_step_cnt←o_step_cnt+1.
  - If o_step_goal=1 or o_step_cnt+1==MAX_STEPS, go to DONE; otherwise go to SELECT.
- DONE: o_episode_done=1 for one cycle; o_episode_cnt←+1. Then go to INIT if i_run=1, else IDLE.
- Deasserting i_run mid-episode does not abort the episode; it completes.
- The goal check takes priority over the step limit; both end the episode identically.
- Counter arithmetic is unsigned. The step counter cannot overflow, given the MAX_STEPS constraint.

## Timing

- Reset (synchronous, i_rst_n=0 at a rising edge):
  - FSM→IDLE; o_st=START_STATE; o_at=0; all o_step_* =0; o_step_cnt=0; o_episode_cnt=0; retry=0.
  - o_rand_req, o_step_valid, o_episode_done, o_busy all 0.
- Reset asserted in any state, including ISSUE with valid high, takes effect at the next edge. No handshake completes on that edge.
- Step latency with i_step_ready tied high: SELECT, EVAL, ISSUE = 3 cycles per step. Each wall retry adds 2 cycles.
- Episode overhead: INIT 1 cycle + DONE 1 cycle.
- o_step_valid rises the cycle after EVAL; o_episode_done is asserted the cycle after the final handshake.
- o_busy rises the cycle after i_run is sampled high in IDLE.

## Test plan

- Reset: hold i_rst_n=0 for 2 cycles with i_run=1 → o_st=0, o_busy=0, no pulses; first o_rand_req appears 2 cycles after release.
- Direct path: i_random_action sequence 00,00,00,00,11,11,11,11, ready high → 8 handshakes with s'=1,2,3,4,9,14,19,24; o_step_goal=1 on the last only; o_episode_done one cycle later; o_step_cnt=8; o_episode_cnt=1; handshakes 3 cycles apart.
- Wall retry: at state 0 feed 01 then 00 → two o_rand_req pulses; one handshake (s=0, a=00, s'=1, wall=0).
- Forced self-loop (MAX_RETRIES=4): at state 0 feed 01 four times → one handshake (s=0, a=01, s'=0, wall=1) after 4 SELECT pulses.
- Step limit (MAX_STEPS=6): alternate 00/10 from state 0 → done after handshake 6; o_step_goal=0; next episode restarts at state 0 if i_run=1, else IDLE.
- Backpressure and reset: hold i_step_ready=0 for 5 cycles in ISSUE → o_step_* stable and o_st unchanged; then pull i_rst_n low with valid high → IDLE next edge, o_step_cnt=0.
